// File: rtl/ev_lat_tracker.sv
// Event latency tracker: pairs start/end events by ID and queues latency records in a show-ahead FIFO.
// Define EV_LAT_TIMEOUT_EN to build the expiry scanner that retires stale IDs as out_kind=1 records.
module ev_lat_tracker #(
    parameter int ID_W      = 4,
    parameter int TS_W      = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    input  logic [TS_W-1:0] timeout_cycles,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic            out_kind,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_delta,
    output logic [ID_W:0]   active_count
);
    localparam int NUM_IDS = 1 << ID_W;
    localparam int PTR_W   = $clog2(OUT_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = OUT_DEPTH[CNT_W:0];

    logic [TS_W-1:0]    ts_reg;
    logic [NUM_IDS-1:0] active_reg;
    logic [NUM_IDS-1:0] active_next;
    logic [TS_W-1:0]    start_ts_mem [NUM_IDS];
    logic [ID_W:0]      active_count_reg;
    logic [ID_W:0]      active_count_next;

    logic               pipe_valid_reg;
    logic [ID_W-1:0]    pipe_id_reg;
    logic [TS_W-1:0]    pipe_start_reg;
    logic [TS_W-1:0]    pipe_end_reg;

    logic [ID_W-1:0]    fifo_id_mem    [OUT_DEPTH];
    logic [TS_W-1:0]    fifo_start_mem [OUT_DEPTH];
    logic [TS_W-1:0]    fifo_end_mem   [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   fifo_count_reg;
    logic [CNT_W-1:0]   fifo_count_next;

    logic [CNT_W:0]     occupancy;
    logic               fifo_room;
    logic               start_fire;
    logic               end_fire;
    logic               retire;
    logic [ID_W-1:0]    retire_id;
    logic               fifo_push;
    logic               fifo_pop;

    // Room is judged against queued records plus the one still in the pipeline stage.
    always_comb begin
        occupancy   = {1'b0, fifo_count_reg} + {{CNT_W{1'b0}}, pipe_valid_reg};
        fifo_room   = occupancy < DEPTH_C;
        end_ready   = rst_n && active_reg[end_id] && fifo_room;
        end_fire    = end_valid && end_ready;
        start_ready = rst_n && !active_reg[start_id] && !(end_fire && (end_id == start_id));
        start_fire  = start_valid && start_ready;
    end

`ifdef EV_LAT_TIMEOUT_EN
    logic [ID_W-1:0] scan_ptr_reg;
    logic [TS_W-1:0] scan_elapsed;
    logic            scan_hold;
    logic            expire;
    logic            pipe_kind_reg;
    logic            fifo_kind_mem [OUT_DEPTH];

    // The scanner yields to any end activity so the two never retire in the same cycle.
    always_comb begin
        scan_elapsed = ts_reg - start_ts_mem[scan_ptr_reg];
        scan_hold    = end_fire || (end_valid && (end_id == scan_ptr_reg)) || !fifo_room;
        expire       = !scan_hold && active_reg[scan_ptr_reg] &&
                       (timeout_cycles != '0) && (scan_elapsed >= timeout_cycles);
    end

    assign retire    = end_fire || expire;
    assign retire_id = end_fire ? end_id : scan_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr_reg <= '0;
        end else if (!scan_hold) begin
            scan_ptr_reg <= scan_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (retire) begin
            pipe_kind_reg <= expire;
        end
        if (fifo_push) begin
            fifo_kind_mem[wr_ptr_reg] <= pipe_kind_reg;
        end
    end

    assign out_kind = out_valid && fifo_kind_mem[rd_ptr_reg];
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles;
    assign retire         = end_fire;
    assign retire_id      = end_id;
    assign out_kind       = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_active
        localparam logic [ID_W-1:0] GI_ID = ID_W'(gi);
        assign active_next[gi] = (start_fire && (start_id == GI_ID)) ? 1'b1 :
                                 (retire && (retire_id == GI_ID))    ? 1'b0 :
                                 active_reg[gi];
    end

    assign fifo_push = pipe_valid_reg;
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        active_count_next = active_count_reg;
        case ({start_fire, retire})
            2'b10:   active_count_next = active_count_reg + 1'b1;
            2'b01:   active_count_next = active_count_reg - 1'b1;
            default: active_count_next = active_count_reg;
        endcase
        fifo_count_next = fifo_count_reg;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
            2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg           <= '0;
            active_reg       <= '0;
            active_count_reg <= '0;
            pipe_valid_reg   <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
        end else begin
            ts_reg           <= ts_reg + 1'b1;
            active_reg       <= active_next;
            active_count_reg <= active_count_next;
            pipe_valid_reg   <= retire;
            fifo_count_reg   <= fifo_count_next;
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage arrays carry no reset so they map onto RAM; the start time is read out registered.
    always_ff @(posedge clk) begin
        if (start_fire) begin
            start_ts_mem[start_id] <= ts_reg;
        end
        if (retire) begin
            pipe_id_reg    <= retire_id;
            pipe_start_reg <= start_ts_mem[retire_id];
            pipe_end_reg   <= ts_reg;
        end
        if (fifo_push) begin
            fifo_id_mem[wr_ptr_reg]    <= pipe_id_reg;
            fifo_start_mem[wr_ptr_reg] <= pipe_start_reg;
            fifo_end_mem[wr_ptr_reg]   <= pipe_end_reg;
        end
    end

    assign out_valid    = fifo_count_reg != '0;
    assign active_count = active_count_reg;

    // Fields are masked by out_valid so an empty or reset FIFO presents all zeros.
    always_comb begin
        out_id       = '0;
        out_start_ts = '0;
        out_end_ts   = '0;
        if (out_valid) begin
            out_id       = fifo_id_mem[rd_ptr_reg];
            out_start_ts = fifo_start_mem[rd_ptr_reg];
            out_end_ts   = fifo_end_mem[rd_ptr_reg];
        end
        out_delta = out_end_ts - out_start_ts;
    end

endmodule

// File: tb/tb_ev_lat_tracker.sv
// Directed bench for ev_lat_tracker: 64-bit instance for the main scenarios, 8-bit instance for wrap.
module tb_ev_lat_tracker;
    localparam int ID_W = 4;
    localparam int TS_W = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [ID_W-1:0] start_id = '0;
    logic            end_valid = 1'b0;
    logic            end_ready;
    logic [ID_W-1:0] end_id = '0;
    logic [TS_W-1:0] timeout_cycles = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ID_W-1:0] out_id;
    logic            out_kind;
    logic [TS_W-1:0] out_start_ts;
    logic [TS_W-1:0] out_end_ts;
    logic [TS_W-1:0] out_delta;
    logic [ID_W:0]   active_count;

    logic            s8_valid = 1'b0;
    logic            s8_ready;
    logic [ID_W-1:0] s8_id = '0;
    logic            e8_valid = 1'b0;
    logic            e8_ready;
    logic [ID_W-1:0] e8_id = '0;
    logic [7:0]      t8 = '0;
    logic            o8_valid;
    logic            o8_ready = 1'b1;
    logic [ID_W-1:0] o8_id;
    logic            o8_kind;
    logic [7:0]      o8_start;
    logic [7:0]      o8_end;
    logic [7:0]      o8_delta;
    logic [ID_W:0]   o8_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] tb_ts;

    ev_lat_tracker #(.ID_W(ID_W), .TS_W(TS_W), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
        .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
        .timeout_cycles(timeout_cycles),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_kind(out_kind),
        .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
        .active_count(active_count)
    );

    ev_lat_tracker #(.ID_W(ID_W), .TS_W(8), .OUT_DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s8_valid), .start_ready(s8_ready), .start_id(s8_id),
        .end_valid(e8_valid), .end_ready(e8_ready), .end_id(e8_id),
        .timeout_cycles(t8),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_id(o8_id), .out_kind(o8_kind),
        .out_start_ts(o8_start), .out_end_ts(o8_end), .out_delta(o8_delta),
        .active_count(o8_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: same free-running count the tracker is expected to keep.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 64'd1;
    end

    task automatic wait_ts(input logic [63:0] t);
        int n;
        n = 0;
        while (tb_ts != t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tb_ts != t) begin
            checks++; errors++;
            $display("FAIL wait_ts: reached %0d, required %0d", tb_ts, t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_valid = 1'b1; start_id = 4'd0; end_valid = 1'b1; end_id = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL rst_start_ready: got %b want 0", start_ready); end
        checks++; if (end_ready !== 1'b0) begin errors++; $display("FAIL rst_end_ready: got %b want 0", end_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL rst_active_count: got %0d want 0", active_count); end
        checks++; if (out_delta !== 64'd0) begin errors++; $display("FAIL rst_out_delta: got %0d want 0", out_delta); end
        start_valid = 1'b0; end_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: released at tb_ts=%0d", tb_ts);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        wait_ts(64'd10);
        start_valid = 1'b1; start_id = 4'd3;
        #1;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL basic_start_ready: got %b want 1", start_ready); end
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL basic_active_up: got %0d want 1", active_count); end
        wait_ts(64'd25);
        end_valid = 1'b1; end_id = 4'd3;
        #1;
        checks++; if (end_ready !== 1'b1) begin errors++; $display("FAIL basic_end_ready: got %b want 1", end_ready); end
        @(negedge clk);
        end_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid %b want 0", out_valid); end
        checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL basic_active_down: got %0d want 0", active_count); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        checks++; if (out_id !== 4'd3 || out_kind !== 1'b0) begin errors++; $display("FAIL basic_id_kind: got id %0d kind %b want id 3 kind 0", out_id, out_kind); end
        checks++; if (out_start_ts !== 64'd10 || out_end_ts !== 64'd25) begin errors++; $display("FAIL basic_ts: got start %0d end %0d want 10 25", out_start_ts, out_end_ts); end
        checks++; if (out_delta !== 64'd15) begin errors++; $display("FAIL basic_delta: got %0d want 15", out_delta); end
        $display("basic: id=%0d start=%0d end=%0d delta=%0d", out_id, out_start_ts, out_end_ts, out_delta);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_same_id();
        out_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b1; start_id = 4'd5;
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL same_pre_count: got %0d want 1", active_count); end
        @(negedge clk);
        start_valid = 1'b1; start_id = 4'd5; end_valid = 1'b1; end_id = 4'd5;
        #1;
        checks++; if (end_ready !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL same_collide: end_ready %b start_ready %b want 1 0", end_ready, start_ready); end
        @(negedge clk);
        end_valid = 1'b0;
        #1;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL same_retry_ready: got %b want 1", start_ready); end
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL same_post_count: got %0d want 1", active_count); end
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd5) begin errors++; $display("FAIL same_record: valid %b id %0d want 1 5", out_valid, out_id); end
        $display("same_id: record id=%0d delta=%0d active=%0d", out_id, out_delta, active_count);
        @(negedge clk);
        end_valid = 1'b1; end_id = 4'd5;
        @(negedge clk);
        end_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (active_count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL same_cleanup: active %0d valid %b want 0 0", active_count, out_valid); end
    endtask

    task automatic test_backpressure();
        int seen;
        int nxt;
        logic fire;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_valid = 1'b1; start_id = i[3:0];
            #1;
            checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_start_%0d: got %b want 1", i, start_ready); end
        end
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++; if (active_count !== 5'd6) begin errors++; $display("FAIL bp_active6: got %0d want 6", active_count); end
        for (int i = 0; i < 4; i++) begin
            end_valid = 1'b1; end_id = i[3:0];
            #1;
            checks++; if (end_ready !== 1'b1) begin errors++; $display("FAIL bp_end_%0d: got %b want 1", i, end_ready); end
            @(negedge clk);
        end
        end_id = 4'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (end_ready !== 1'b0) begin errors++; $display("FAIL bp_full_%0d: end_ready %b want 0", i, end_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (active_count !== 5'd2) begin errors++; $display("FAIL bp_active2: got %0d want 2", active_count); end
        out_ready = 1'b1;
        seen = 0; nxt = 4;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            #1;
            fire = end_valid && end_ready;
            if (out_valid) begin
                checks++;
                if (out_id !== seen[3:0]) begin errors++; $display("FAIL bp_order_%0d: got id %0d want %0d", seen, out_id, seen); end
                $display("backpressure: drained id=%0d", out_id);
                seen++;
            end
            @(negedge clk);
            if (fire) begin
                if (nxt == 4) begin nxt = 5; end_id = 4'd5; end
                else end_valid = 1'b0;
            end
        end
        end_valid = 1'b0;
        checks++; if (seen != 6) begin errors++; $display("FAIL bp_total: got %0d records want 6", seen); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (active_count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: active %0d valid %b want 0 0", active_count, out_valid); end
    endtask

    task automatic test_timeout();
        logic [63:0] st;
        int got;
        logic [ID_W-1:0] g_id;
        logic g_kind;
        logic [63:0] g_start, g_end, g_delta;
        timeout_cycles = 64'd20;
        out_ready = 1'b1;
        got = 0; g_id = '0; g_kind = 1'b0; g_start = '0; g_end = '0; g_delta = '0;
        @(negedge clk);
        st = tb_ts;
        start_valid = 1'b1; start_id = 4'd7;
        @(negedge clk);
        start_valid = 1'b0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                got = 1; g_id = out_id; g_kind = out_kind;
                g_start = out_start_ts; g_end = out_end_ts; g_delta = out_delta;
            end
        end
`ifdef EV_LAT_TIMEOUT_EN
        checks++; if (got != 1) begin errors++; $display("FAIL to_record: got %0d records want 1", got); end
        checks++; if (g_id !== 4'd7 || g_kind !== 1'b1) begin errors++; $display("FAIL to_id_kind: got id %0d kind %b want 7 1", g_id, g_kind); end
        checks++; if (g_start !== st) begin errors++; $display("FAIL to_start: got %0d want %0d", g_start, st); end
        checks++; if (g_delta < 64'd20 || g_delta > 64'd35 || g_end - g_start !== g_delta) begin errors++; $display("FAIL to_delta: got %0d end %0d want 20..35", g_delta, g_end); end
        $display("timeout: id=%0d kind=%b delta=%0d", g_id, g_kind, g_delta);
        @(negedge clk);
        end_valid = 1'b1; end_id = 4'd7;
        #1;
        checks++; if (active_count !== 5'd0) begin errors++; $display("FAIL to_active: got %0d want 0", active_count); end
        checks++; if (end_ready !== 1'b0) begin errors++; $display("FAIL to_end_ready: got %b want 0", end_ready); end
        @(negedge clk);
        end_valid = 1'b0;
`else
        checks++; if (got != 0) begin errors++; $display("FAIL noto_record: got %0d records want 0 (id %0d kind %b)", got, g_id, g_kind); end
        checks++; if (active_count !== 5'd1) begin errors++; $display("FAIL noto_active: got %0d want 1", active_count); end
        @(negedge clk);
        end_valid = 1'b1; end_id = 4'd7;
        #1;
        checks++; if (end_ready !== 1'b1) begin errors++; $display("FAIL noto_end_ready: got %b want 1", end_ready); end
        @(negedge clk);
        end_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 4'd7 || out_kind !== 1'b0 || out_start_ts !== st) begin
            errors++; $display("FAIL noto_end_record: valid %b id %0d kind %b start %0d want 1 7 0 %0d", out_valid, out_id, out_kind, out_start_ts, st);
        end
        $display("timeout disabled: id=%0d kind=%b delta=%0d", out_id, out_kind, out_delta);
`endif
        timeout_cycles = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [ID_W-1:0] ids [5];
        ids[0] = 4'd8; ids[1] = 4'd9; ids[2] = 4'd10; ids[3] = 4'd1; ids[4] = 4'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1; start_id = ids[i];
        end
        @(negedge clk);
        start_valid = 1'b0;
        for (int i = 3; i < 5; i++) begin
            end_valid = 1'b1; end_id = ids[i];
            @(negedge clk);
        end
        end_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || active_count !== 5'd3) begin errors++; $display("FAIL rm_pre: valid %b active %0d want 1 3", out_valid, active_count); end
        rst_n = 1'b0; start_valid = 1'b1; start_id = 4'd8; end_valid = 1'b1; end_id = 4'd8;
        #1;
        checks++; if (out_valid !== 1'b0 || active_count !== 5'd0) begin errors++; $display("FAIL rm_async: valid %b active %0d want 0 0", out_valid, active_count); end
        checks++; if (out_id !== 4'd0 || out_end_ts !== 64'd0) begin errors++; $display("FAIL rm_fields: id %0d end %0d want 0 0", out_id, out_end_ts); end
        checks++; if (start_ready !== 1'b0 || end_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: start %b end %b want 0 0", start_ready, end_ready); end
        start_valid = 1'b0; end_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_valid = 1'b1; start_id = ids[i];
            #1;
            checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rm_restart_%0d: got %b want 1", i, start_ready); end
        end
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++; if (active_count !== 5'd3) begin errors++; $display("FAIL rm_restarted: got %0d want 3", active_count); end
        $display("reset_mid: active after restart=%0d", active_count);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        o8_ready = 1'b1;
        wait_ts(64'd250);
        s8_valid = 1'b1; s8_id = 4'd1;
        #1;
        checks++; if (s8_ready !== 1'b1) begin errors++; $display("FAIL wrap_start_ready: got %b want 1", s8_ready); end
        @(negedge clk);
        s8_valid = 1'b0;
        wait_ts(64'd260);
        e8_valid = 1'b1; e8_id = 4'd1;
        #1;
        checks++; if (e8_ready !== 1'b1) begin errors++; $display("FAIL wrap_end_ready: got %b want 1", e8_ready); end
        @(negedge clk);
        e8_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (o8_valid !== 1'b1 || o8_start !== 8'd250 || o8_end !== 8'd4) begin errors++; $display("FAIL wrap_ts: valid %b start %0d end %0d want 1 250 4", o8_valid, o8_start, o8_end); end
        checks++; if (o8_delta !== 8'd10) begin errors++; $display("FAIL wrap_delta: got %0d want 10", o8_delta); end
        $display("wrap: start=%0d end=%0d delta=%0d", o8_start, o8_end, o8_delta);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_id();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
